// File: rtl/arch_map_rr_pkg.sv
// Shared definitions for the retirement architectural map: sizing defaults, FSM states, bus payloads.
package arch_map_rr_pkg;

    localparam int unsigned NUM_ARCH   = 32;
    localparam int unsigned NUM_PR     = 64;
    localparam int unsigned NUM_SUPER  = 2;
    localparam int unsigned ZERO_REG   = 31;
    localparam int unsigned COPY_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } ARCH_MAP_RR_STATE_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0]                  retire_en;
        logic [NUM_SUPER-1:0][$clog2(NUM_ARCH)-1:0] dest_idx;
        logic [NUM_SUPER-1:0][$clog2(NUM_PR)-1:0]   T_idx;
    } ROB_ARCH_MAP_RR_OUT_t;

    typedef struct packed {
        logic                                       copy_valid;
        logic [$clog2(NUM_ARCH/COPY_WIDTH)-1:0]     copy_beat;
        logic [COPY_WIDTH-1:0][$clog2(NUM_PR)-1:0]  copy_map;
        logic                                       copy_done;
    } ARCH_MAP_RR_MAP_TABLE_OUT_t;

    // Beat counter width; a single-beat restore still needs one bit.
    function automatic int unsigned beat_bits(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/arch_map_rr_merge.sv
// In-order merge of retiring slots into the committed map, with intra-cycle Told bypass.
module arch_map_rr_merge #(
    parameter  int unsigned NUM_ARCH  = 32,
    parameter  int unsigned NUM_PR    = 64,
    parameter  int unsigned NUM_SUPER = 2,
    parameter  int unsigned ZERO_REG  = 31,
    localparam int unsigned PRW       = $clog2(NUM_PR),
    localparam int unsigned ARW       = $clog2(NUM_ARCH)
) (
    input  logic [NUM_ARCH*PRW-1:0]  i_cur_map,
    input  logic                     i_block,
    input  logic [NUM_SUPER-1:0]     i_retire_en,
    input  logic [NUM_SUPER*ARW-1:0] i_dest_idx,
    input  logic [NUM_SUPER*PRW-1:0] i_T_idx,
    output logic [NUM_ARCH*PRW-1:0]  o_next_map,
    output logic [NUM_SUPER*PRW-1:0] o_told_idx,
    output logic [NUM_SUPER-1:0]     o_told_valid
);
    import arch_map_rr_pkg::*;

    always_comb begin
        logic [PRW-1:0] m [NUM_ARCH];
        o_told_idx   = '0;
        o_told_valid = '0;
        o_next_map   = '0;
        for (int a = 0; a < NUM_ARCH; a++) begin
            m[a] = i_cur_map[a*PRW +: PRW];
        end
        // Each slot sees the map as left by all older slots in the same cycle.
        for (int s = 0; s < NUM_SUPER; s++) begin
            o_told_idx[s*PRW +: PRW] = m[i_dest_idx[s*ARW +: ARW]];
            o_told_valid[s] = i_retire_en[s] && !i_block &&
                              (i_dest_idx[s*ARW +: ARW] != ARW'(ZERO_REG));
            if (o_told_valid[s]) begin
                m[i_dest_idx[s*ARW +: ARW]] = i_T_idx[s*PRW +: PRW];
            end
        end
        for (int a = 0; a < NUM_ARCH; a++) begin
            o_next_map[a*PRW +: PRW] = m[a];
        end
    end

endmodule

// File: rtl/arch_map_rr.sv
// Retirement architectural map: commits retiring mappings and streams the map back on rollback.
module arch_map_rr #(
    parameter  int unsigned NUM_ARCH   = 32,
    parameter  int unsigned NUM_PR     = 64,
    parameter  int unsigned NUM_SUPER  = 2,
    parameter  int unsigned ZERO_REG   = 31,
    parameter  int unsigned COPY_WIDTH = 8,
    localparam int unsigned PRW        = $clog2(NUM_PR),
    localparam int unsigned ARW        = $clog2(NUM_ARCH),
    localparam int unsigned BEATS      = NUM_ARCH / COPY_WIDTH,
    localparam int unsigned BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_SUPER-1:0]      retire_en,
    input  logic [NUM_SUPER*ARW-1:0]  retire_dest_idx,
    input  logic [NUM_SUPER*PRW-1:0]  retire_T_idx,
    output logic [NUM_SUPER*PRW-1:0]  retire_Told_idx,
    output logic [NUM_SUPER-1:0]      retire_Told_valid,
    input  logic                      rollback_req,
    output logic                      copy_valid,
    input  logic                      copy_ready,
    output logic [BW-1:0]             copy_beat,
    output logic [COPY_WIDTH*PRW-1:0] copy_map,
    output logic                      copy_done,
    output logic                      busy,
    output logic [NUM_ARCH*PRW-1:0]   arch_map_out
);
    import arch_map_rr_pkg::*;

    localparam int unsigned MW = $clog2(NUM_ARCH * PRW);

    ARCH_MAP_RR_STATE_t          r_state;
    ARCH_MAP_RR_STATE_t          w_state_next;
    logic [BW-1:0]               r_beat;
    logic [BW-1:0]               w_beat_next;
    logic                        r_done;
    logic                        w_done_next;
    logic [NUM_ARCH*PRW-1:0]     r_map;
    logic [NUM_ARCH*PRW-1:0]     w_next_map;
    logic [MW-1:0]               w_copy_base;

    arch_map_rr_merge #(
        .NUM_ARCH  (NUM_ARCH),
        .NUM_PR    (NUM_PR),
        .NUM_SUPER (NUM_SUPER),
        .ZERO_REG  (ZERO_REG)
    ) u_merge (
        .i_cur_map    (r_map),
        .i_block      (busy),
        .i_retire_en  (retire_en),
        .i_dest_idx   (retire_dest_idx),
        .i_T_idx      (retire_T_idx),
        .o_next_map   (w_next_map),
        .o_told_idx   (retire_Told_idx),
        .o_told_valid (retire_Told_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Restore sequencing; a fresh rollback always restarts the stream at beat 0.
    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_done_next  = r_done;
        if (en) begin
            w_done_next = 1'b0;
            case (r_state)
                IDLE: begin
                    if (rollback_req) begin
                        w_state_next = COPY;
                        w_beat_next  = '0;
                    end
                end
                COPY: begin
                    if (rollback_req) begin
                        w_beat_next = '0;
                    end else if (copy_ready) begin
                        if (r_beat == BW'(BEATS - 1)) begin
                            w_state_next = IDLE;
                            w_beat_next  = '0;
                            w_done_next  = 1'b1;
                        end else begin
                            w_beat_next = r_beat + BW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Retirement is blocked in COPY by the merge, so the map is stable while streaming.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_beat <= '0;
            r_done <= 1'b0;
            for (int i = 0; i < NUM_ARCH; i++) begin
                r_map[i*PRW +: PRW] <= PRW'(i);
            end
        end else begin
            r_beat <= w_beat_next;
            r_done <= w_done_next;
            if (en) begin
                r_map <= w_next_map;
            end
        end
    end

    assign w_copy_base  = MW'(r_beat) * MW'(COPY_WIDTH * PRW);
    assign busy         = (r_state == COPY);
    assign copy_valid   = busy;
    assign copy_beat    = r_beat;
    assign copy_map     = r_map[w_copy_base +: COPY_WIDTH*PRW];
    assign copy_done    = r_done;
    assign arch_map_out = r_map;

    // The ROB is flushed during a restore, so nothing may retire then.
    always @(posedge clock) begin
        if (!reset && busy) begin
            assert (retire_en == '0)
                else $error("arch_map_rr: retire_en=%b asserted during restore", retire_en);
        end
    end

endmodule

// File: tb/tb_arch_map_rr.sv
// Directed bench for arch_map_rr: retire merging, zero-reg handling, restore streaming and aborts.
module tb_arch_map_rr;

    localparam int unsigned NA    = 32;
    localparam int unsigned NP    = 64;
    localparam int unsigned NS    = 2;
    localparam int unsigned ZR    = 31;
    localparam int unsigned CW    = 8;
    localparam int unsigned PRW   = 6;
    localparam int unsigned ARW   = 5;
    localparam int unsigned BW    = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 en;
    logic [NS-1:0]        retire_en;
    logic [NS*ARW-1:0]    retire_dest_idx;
    logic [NS*PRW-1:0]    retire_T_idx;
    logic [NS*PRW-1:0]    retire_Told_idx;
    logic [NS-1:0]        retire_Told_valid;
    logic                 rollback_req;
    logic                 copy_valid;
    logic                 copy_ready;
    logic [BW-1:0]        copy_beat;
    logic [CW*PRW-1:0]    copy_map;
    logic                 copy_done;
    logic                 busy;
    logic [NA*PRW-1:0]    arch_map_out;

    int total = 0;
    int bad   = 0;
    logic [PRW-1:0] exp_map [NA];

    arch_map_rr #(
        .NUM_ARCH   (NA),
        .NUM_PR     (NP),
        .NUM_SUPER  (NS),
        .ZERO_REG   (ZR),
        .COPY_WIDTH (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .en                (en),
        .retire_en         (retire_en),
        .retire_dest_idx   (retire_dest_idx),
        .retire_T_idx      (retire_T_idx),
        .retire_Told_idx   (retire_Told_idx),
        .retire_Told_valid (retire_Told_valid),
        .rollback_req      (rollback_req),
        .copy_valid        (copy_valid),
        .copy_ready        (copy_ready),
        .copy_beat         (copy_beat),
        .copy_map          (copy_map),
        .copy_done         (copy_done),
        .busy              (busy),
        .arch_map_out      (arch_map_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_map(input string tag);
        logic [NA*PRW-1:0] e;
        for (int i = 0; i < NA; i++) e[i*PRW +: PRW] = exp_map[i];
        total++;
        assert (arch_map_out === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, arch_map_out, e);
        end
    endtask

    function automatic logic [CW*PRW-1:0] exp_beat(input int b);
        logic [CW*PRW-1:0] v;
        for (int j = 0; j < CW; j++) v[j*PRW +: PRW] = exp_map[b*CW + j];
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NA; i++) exp_map[i] = PRW'(i);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; retire_en = '0; retire_dest_idx = '0; retire_T_idx = '0;
        rollback_req = 1'b0; copy_ready = 1'b0;
        reset_model();
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_valid", copy_valid, 0);
        chk("rst_done", copy_done, 0);
        chk_map("rst_map");

        // Full restore with copy_ready held high
        rollback_req = 1'b1; copy_ready = 1'b1;
        step();
        rollback_req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("cp_valid_b%0d", b), copy_valid, 1);
            chk($sformatf("cp_beat_b%0d", b), copy_beat, b);
            chk($sformatf("cp_map_b%0d", b), copy_map, exp_beat(b));
            chk($sformatf("cp_nodone_b%0d", b), copy_done, 0);
            step();
        end
        chk("cp_done", copy_done, 1);
        chk("cp_idle", busy, 0);
        step();
        chk("cp_done_pulse", copy_done, 0);

        // Dual retire to the same dest: slot1 sees slot0's write
        retire_en = 2'b11; retire_dest_idx = {5'd5, 5'd5}; retire_T_idx = {6'd41, 6'd40};
        #1;
        chk("dual_told", retire_Told_idx, {6'd40, 6'd5});
        chk("dual_tv", retire_Told_valid, 2'b11);
        step();
        retire_en = '0;
        exp_map[5] = 6'd41;
        chk_map("dual_map");

        // Zero-reg slot ignored
        retire_en = 2'b11; retire_dest_idx = {5'd2, 5'd31}; retire_T_idx = {6'd51, 6'd50};
        #1;
        chk("zr_tv", retire_Told_valid, 2'b10);
        chk("zr_told1", retire_Told_idx[PRW +: PRW], 6'd2);
        step();
        retire_en = '0;
        exp_map[2] = 6'd51;
        chk_map("zr_map");

        // Backpressure on beat 1 for three cycles
        rollback_req = 1'b1; copy_ready = 1'b1;
        step();
        rollback_req = 1'b0;
        chk("bp_beat0", copy_beat, 0);
        chk("bp_map0", copy_map, exp_beat(0));
        step();
        copy_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_hold_beat%0d", k), copy_beat, 1);
            chk($sformatf("bp_hold_map%0d", k), copy_map, exp_beat(1));
            chk($sformatf("bp_hold_busy%0d", k), busy, 1);
        end
        copy_ready = 1'b1;
        step();
        chk("bp_beat2", copy_beat, 2);
        step();
        chk("bp_beat3", copy_beat, 3);
        chk("bp_nodone", copy_done, 0);
        step();
        chk("bp_done7", copy_done, 1);
        step();

        // Retire and rollback in the same cycle, then en low stalls the stream
        retire_en = 2'b01; retire_dest_idx = {5'd0, 5'd3}; retire_T_idx = {6'd0, 6'd60};
        rollback_req = 1'b1; copy_ready = 1'b0;
        step();
        retire_en = '0; rollback_req = 1'b0;
        exp_map[3] = 6'd60;
        chk("rr_beat0", copy_beat, 0);
        chk("rr_map3", copy_map[3*PRW +: PRW], 6'd60);
        en = 1'b0; copy_ready = 1'b1;
        step(); step();
        chk("en0_beat", copy_beat, 0);
        chk("en0_valid", copy_valid, 1);
        en = 1'b1;
        for (int k = 0; k < 10 && !copy_done; k++) step();
        chk("rr_drain_done", copy_done, 1);
        chk_map("rr_map");
        step();

        // Restart at beat 2, then reset mid-stream
        rollback_req = 1'b1; copy_ready = 1'b1;
        step();
        rollback_req = 1'b0;
        step(); step();
        chk("rs_beat2", copy_beat, 2);
        rollback_req = 1'b1;
        step();
        rollback_req = 1'b0;
        chk("rs_beat0", copy_beat, 0);
        chk("rs_nodone", copy_done, 0);
        chk("rs_busy", busy, 1);
        step();
        chk("rs_beat1", copy_beat, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        reset_model();
        chk("mr_busy", busy, 0);
        chk("mr_valid", copy_valid, 0);
        chk("mr_done", copy_done, 0);
        chk_map("mr_map");
        step();
        chk("mr_done_after", copy_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arch_map_rr.md
Name: arch_map_rr

Overview:
- Parametrised retirement (architectural) map for the R10000-style core.
- Holds the committed arch-reg → phys-reg mapping, updated by up to NUM_SUPER retiring instructions per cycle.
- Returns each retiring slot's previous mapping (Told) for the free list.
- On rollback, streams the committed map back to the speculative map table over a narrow ready/valid channel, COPY_WIDTH entries per beat.

Parameters:
- NUM_ARCH, 32, architectural registers; power of two.
- NUM_PR, 64, physical registers.
- NUM_SUPER, 2, retire slots per cycle.
- ZERO_REG, 31, hardwired-zero arch reg; never remapped.
- COPY_WIDTH, 8, map entries per restore beat; NUM_ARCH % COPY_WIDTH == 0.
- Derived:
  - PRW=$clog2(NUM_PR)
  - ARW=$clog2(NUM_ARCH)
  - BEATS=NUM_ARCH/COPY_WIDTH
  - BW=max(1,$clog2(BEATS))

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- en  in  1  global stall-gate; when low, no state changes and no handshake progress
- retire_en  in  NUM_SUPER  per-slot retire valid; slot 0 is oldest
- retire_dest_idx  in  NUM_SUPER×ARW  destination arch reg per slot
- retire_T_idx  in  NUM_SUPER×PRW  new phys reg per slot
- retire_Told_idx  out  NUM_SUPER×PRW  mapping displaced by each slot, combinational
- retire_Told_valid  out  NUM_SUPER  Told is freeable
- rollback_req  in  1  single-cycle pulse: squash, restore map table
- copy_valid  out  1  restore beat valid
- copy_ready  in  1  map table accepts beat
- copy_beat  out  BW  beat index; entries beat*COPY_WIDTH .. +COPY_WIDTH-1
- copy_map  out  COPY_WIDTH×PRW  mappings for the beat
- copy_done  out  1  one-cycle pulse after last beat accepted
- busy  out  1  high while in COPY
- arch_map_out  out  NUM_ARCH×PRW  full registered map, for debug and checkers

Behaviour:
- Reset:
  - arch_map[i]=i for all i.
  - FSM=IDLE; beat counter=0.
  - copy_valid=0, copy_done=0, busy=0.
- Retire (IDLE only, en=1):
  - Slots are applied in order 0..NUM_SUPER-1; a later slot on the same dest overrides an earlier one.
  - Told[i] = mapping of dest[i] after slots 0..i-1 are applied (intra-cycle bypass), not the registered value.
  - retire_Told_valid[i] = retire_en[i] && dest[i]!=ZERO_REG && !busy.
  - A slot with dest==ZERO_REG is ignored: map unchanged, Told_valid=0.
  - The update takes effect at the next edge; arch_map_out shows it one cycle later.
- FSM IDLE:
  - rollback_req && en → COPY, beat=0.
  - Any retires in that same cycle are committed first; the restore streams the post-retire map.
- FSM COPY:
  - copy_valid=1; copy_map = arch_map[beat*COPY_WIDTH +: COPY_WIDTH] (registered map, stable because retire is blocked).
  - copy_valid && copy_ready && en → beat+1.
  - When the last beat (BEATS-1) is accepted → IDLE, with copy_done=1 for exactly the next cycle.
  - copy_map and copy_beat must hold while copy_valid && !copy_ready.
- retire_en asserted during COPY:
  - Ignored: no update, Told_valid=0.
  - Simulation assertion fires (the ROB is flushed, so this is illegal).
- rollback_req during COPY: restart at beat 0. No copy_done for the aborted stream.
- en=0: all registers hold. copy_valid stays asserted but the beat does not advance.
- reset mid-COPY: immediate return to reset state; no copy_done.
- BEATS==1: a single beat; done follows its acceptance.

Decomposition:
- Shared package (sys_defs):
  - NUM_ARCH, NUM_PR, NUM_SUPER, ZERO_REG, COPY_WIDTH.
  - ARCH_MAP_RR_STATE_t enum {IDLE, COPY}.
  - Structs ROB_ARCH_MAP_RR_OUT_t (retire_en, dest_idx, T_idx) and ARCH_MAP_RR_MAP_TABLE_OUT_t (copy_valid, copy_beat, copy_map, copy_done).
- One natural sub-module: arch_map_rr_merge.
  - Combinational in-order slot merge producing next_map and Told[].
  - Unit-testable standalone.

Test Plan:
- Reset, no retire → arch_map_out[i]==i. Rollback with copy_ready=1 gives 4 beats with copy_map beat0 = {0..7} … beat3 = {24..31}, then copy_done one cycle later.
- Dual retire collision: slot0 dest=5 T=40, slot1 dest=5 T=41 → Told0=5, Told1=40, both valid. Next cycle map[5]=41.
- Zero-reg retire: slot0 dest=31 T=50, slot1 dest=2 T=51 → Told_valid=2'b10, map[31]=31, map[2]=51.
- Backpressure: rollback; copy_ready low on beat 1 for 3 cycles → beat1 data stable, no advance, busy high. Total 7 cycles to copy_done.
- Restart and reset: rollback_req again at beat 2 → beat returns to 0 with no copy_done. A later reset at beat 1 → busy=0, map identity, no done.
- Retire+rollback same cycle: dest=3 T=60 with rollback_req → beat0 copy_map[3]==60.
